// File: rtl/srmem_drain.sv
// Drains double-buffered srmem read windows onto one valid/ready stream, lowest valid slot first.
// Optional SRMEM_DRAIN_CNT_EN adds a saturating per-batch accepted-entry counter on batch_cnt.
module srmem_drain #(
  parameter int NUM_RDPORT = 1,
  parameter int DATA_BW    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_RDPORT*(DATA_BW+1)-1:0]   dout_list,
  input  logic                                rdvalid,
  input  logic                                nextready,
  input  logic                                rdlastinfo,
  output logic                                req_pop,
  output logic                                req_newdata,
  output logic                                out_valid,
  output logic [DATA_BW-1:0]                  out_data,
  output logic                                out_last,
  input  logic                                out_ready,
  output logic                                busy
`ifdef SRMEM_DRAIN_CNT_EN
  ,
  output logic [15:0]                         batch_cnt
`endif
);

  localparam int SLOT_W = DATA_BW + 1;
  localparam logic [NUM_RDPORT-1:0] MASK_ONE = NUM_RDPORT'(1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_EMIT,
    ST_ADV,
    ST_GAP
  } state_t;

  state_t                               state_q, state_d;
  logic [NUM_RDPORT-1:0]                mask_q, mask_d;
  logic [NUM_RDPORT-1:0][DATA_BW-1:0]   data_q, data_d;
  logic                                 last_q, last_d;

  logic [NUM_RDPORT-1:0]                win_mask;
  logic [NUM_RDPORT-1:0][DATA_BW-1:0]   win_data;
  logic [NUM_RDPORT-1:0]                sel_oh;
  logic                                 capture;
  logic                                 accept;

  always_comb begin
    win_mask = '0;
    win_data = '0;
    for (int k = 0; k < NUM_RDPORT; k++) begin
      win_mask[k] = dout_list[k*SLOT_W + DATA_BW];
      win_data[k] = dout_list[k*SLOT_W +: DATA_BW];
    end
  end

  // Isolating the lowest set bit makes invalid slots cost no cycles.
  always_comb begin
    sel_oh    = mask_q & (~mask_q + MASK_ONE);
    out_valid = (state_q == ST_EMIT) && (|mask_q);
    out_last  = out_valid && last_q && (mask_q == sel_oh);
    accept    = out_valid && out_ready;
    busy      = (state_q != ST_WAIT);
    out_data  = '0;
    for (int k = 0; k < NUM_RDPORT; k++) begin
      out_data = out_data | (data_q[k] & {DATA_BW{sel_oh[k]}});
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    data_d      = data_q;
    last_d      = last_q;
    req_pop     = 1'b0;
    req_newdata = 1'b0;
    capture     = 1'b0;

    case (state_q)
      ST_WAIT: begin
        capture = rdvalid;
      end
      ST_EMIT: begin
        if (accept) begin
          mask_d = mask_q & ~sel_oh;
        end
        if (mask_d == '0) begin
          state_d = ST_ADV;
        end
      end
      ST_ADV: begin
        if (last_q) begin
          req_newdata = 1'b1;
        end else begin
          req_pop = 1'b1;
        end
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // The srmem flags a ready follow-on window here, so skip WAIT.
        capture = nextready;
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    if (capture) begin
      mask_d  = win_mask;
      data_d  = win_data;
      last_d  = rdlastinfo;
      state_d = ST_EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
      mask_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

`ifdef SRMEM_DRAIN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req_newdata) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign batch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_srmem_drain.sv
// Directed bench for srmem_drain with a 4-slot window; counter checks build only with SRMEM_DRAIN_CNT_EN.
module tb_srmem_drain;

  localparam int NP = 4;
  localparam int DB = 8;
  localparam int W  = NP * (DB + 1);

  // slot0 = lowest 9 bits; MSB of each slot is its valid bit
  localparam logic [W-1:0] W_A   = {9'h144, 9'h133, 9'h022, 9'h111};
  localparam logic [W-1:0] W_INV = {9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
  localparam logic [W-1:0] W_B   = {9'h0EE, 9'h166, 9'h077, 9'h155};

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  dout_list;
  logic          rdvalid;
  logic          nextready;
  logic          rdlastinfo;
  logic          req_pop;
  logic          req_newdata;
  logic          out_valid;
  logic [DB-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
`ifdef SRMEM_DRAIN_CNT_EN
  logic [15:0]   batch_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  srmem_drain #(.NUM_RDPORT(NP), .DATA_BW(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .dout_list  (dout_list),
    .rdvalid    (rdvalid),
    .nextready  (nextready),
    .rdlastinfo (rdlastinfo),
    .req_pop    (req_pop),
    .req_newdata(req_newdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef SRMEM_DRAIN_CNT_EN
    ,
    .batch_cnt  (batch_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let input changes settle, then compare every output for this cycle.
  task automatic cyc(input string tag, input logic vld, input logic [7:0] dat, input logic lst,
                     input logic pop, input logic nd, input logic bsy);
    #1;
    check({tag, ".vld"},  32'(out_valid),   32'(vld));
    if (vld) check({tag, ".dat"}, 32'(out_data), 32'(dat));
    check({tag, ".last"}, 32'(out_last),    32'(lst));
    check({tag, ".pop"},  32'(req_pop),     32'(pop));
    check({tag, ".nd"},   32'(req_newdata), 32'(nd));
    check({tag, ".busy"}, 32'(busy),        32'(bsy));
  endtask

  initial begin
    rst = 1'b1; rdvalid = 1'b0; nextready = 1'b0; rdlastinfo = 1'b0;
    dout_list = '0; out_ready = 1'b1;
    tick; tick;
    cyc("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 1: three valid slots, not last -> 11,33,44 back to back, then req_pop
    rdvalid = 1'b1; dout_list = W_A; rdlastinfo = 1'b0;
    cyc("t1.wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    rdvalid = 1'b0; dout_list = W_INV;
    cyc("t1.e0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t1.e1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t1.e2", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t1.adv", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); tick;
    cyc("t1.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick;

    // 2: same window, last batch -> out_last on 44, req_newdata
    rdvalid = 1'b1; dout_list = W_A; rdlastinfo = 1'b1;
    cyc("t2.wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    rdvalid = 1'b0;
    cyc("t2.e0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t2.e1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t2.e2", 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    cyc("t2.adv", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); tick;
    nextready = 1'b1; rdvalid = 1'b1; dout_list = W_A; rdlastinfo = 1'b0;
    cyc("t2.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick;

    // 3: back-to-back capture from GAP, then stall 5 cycles on 33
    nextready = 1'b0; rdvalid = 1'b0;
    cyc("t3.e0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("t3.hold%0d", i), 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    end
    out_ready = 1'b1;
    cyc("t3.e1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t3.e2", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t3.adv", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); tick;
    cyc("t3.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick;

    // 4: all-invalid window flagged last -> no output, req_newdata once
    rdvalid = 1'b1; dout_list = W_INV; rdlastinfo = 1'b1;
    cyc("t4.wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    rdvalid = 1'b0;
    cyc("t4.emit", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t4.adv", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); tick;
    cyc("t4.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick;

    // 5: reset while presenting the second entry, then re-read from slot 0
    rdvalid = 1'b1; dout_list = W_A; rdlastinfo = 1'b0;
    cyc("t5.wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    rdvalid = 1'b0;
    cyc("t5.e0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    rst = 1'b1;
    cyc("t5.e1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    rst = 1'b0; rdvalid = 1'b1;
    cyc("t5.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    rdvalid = 1'b0;
    cyc("t5.r0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t5.r1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t5.r2", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    cyc("t5.adv", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); tick;
    cyc("t5.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick;

`ifdef SRMEM_DRAIN_CNT_EN
    // 6: batch of 3+2 entries, last flag on the second window
    rst = 1'b1; tick; rst = 1'b0;
    rdvalid = 1'b1; dout_list = W_A; rdlastinfo = 1'b0;
    cyc("t6.wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); check("t6.cnt.wait", 32'(batch_cnt), 32'd0); tick;
    rdvalid = 1'b0;
    cyc("t6.a0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); check("t6.cnt.a0", 32'(batch_cnt), 32'd0); tick;
    cyc("t6.a1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1); check("t6.cnt.a1", 32'(batch_cnt), 32'd1); tick;
    cyc("t6.a2", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1); check("t6.cnt.a2", 32'(batch_cnt), 32'd2); tick;
    cyc("t6.aadv", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); check("t6.cnt.aadv", 32'(batch_cnt), 32'd3); tick;
    nextready = 1'b1; rdvalid = 1'b1; dout_list = W_B; rdlastinfo = 1'b1;
    cyc("t6.agap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); check("t6.cnt.agap", 32'(batch_cnt), 32'd3); tick;
    nextready = 1'b0; rdvalid = 1'b0;
    cyc("t6.b0", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1); check("t6.cnt.b0", 32'(batch_cnt), 32'd3); tick;
    cyc("t6.b1", 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1); check("t6.cnt.last", 32'(batch_cnt), 32'd4); tick;
    cyc("t6.badv", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); check("t6.cnt.after", 32'(batch_cnt), 32'd5); tick;
    cyc("t6.bgap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); check("t6.cnt.clr", 32'(batch_cnt), 32'd0); tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
